// File: rtl/pll_lock_sequencer_if.sv
// PLL-side and system-side signals of the lock sequencer.
// The master modport is the sequencer's view; slave is the PLL/system view.
interface pll_lock_sequencer_if #(
  parameter int CNT_WIDTH = 8
);
  logic                 LOCKED;
  logic                 PWRDWN_REQ;
  logic                 PLL_RST;
  logic                 PLL_PWRDWN;
  logic                 SYS_RST;
  logic                 READY;
  logic                 TIMEOUT_ERR;
  logic [CNT_WIDTH-1:0] RETRY_CNT;
  logic [CNT_WIDTH-1:0] LOSS_CNT;

  modport master (
    input  LOCKED, PWRDWN_REQ,
    output PLL_RST, PLL_PWRDWN, SYS_RST, READY, TIMEOUT_ERR, RETRY_CNT, LOSS_CNT
  );

  modport slave (
    output LOCKED, PWRDWN_REQ,
    input  PLL_RST, PLL_PWRDWN, SYS_RST, READY, TIMEOUT_ERR, RETRY_CNT, LOSS_CNT
  );
endinterface

// File: rtl/pll_lock_sequencer.sv
// Pulses PLL reset, waits for a stable synchronized lock, then releases the
// downstream system reset; retries on timeout and restarts on lock loss.
module pll_lock_sequencer #(
  parameter int RST_CYCLES    = 8,
  parameter int LOCK_TIMEOUT  = 1000,
  parameter int STABLE_CYCLES = 16,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_WIDTH     = 8
) (
  input logic                  CLK,
  input logic                  RST,
  pll_lock_sequencer_if.master bus
);

  localparam int CNT_MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_MAX   = (CNT_MAX_A > STABLE_CYCLES) ? CNT_MAX_A : STABLE_CYCLES;
  localparam int CW        = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] RST_LAST     = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [31:0]   MAX_R        = 32'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET,
    S_WAIT,
    S_STABLE,
    S_RUN,
    S_FAIL,
    S_PWRDN
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [CW-1:0]        r_cnt;
  logic [CW-1:0]        w_cnt;
  logic                 r_sync1;
  logic                 r_sync2;
  logic [CNT_WIDTH-1:0] r_retry_cnt;
  logic [CNT_WIDTH-1:0] r_loss_cnt;
  logic [CNT_WIDTH-1:0] w_retry_cnt;
  logic [CNT_WIDTH-1:0] w_loss_cnt;
  logic [CNT_WIDTH-1:0] w_retry_inc;
  logic [CNT_WIDTH-1:0] w_loss_inc;

  logic r_pll_rst, r_pll_pwrdwn, r_sys_rst, r_ready, r_timeout_err;
  logic w_pll_rst, w_pll_pwrdwn, w_sys_rst, w_ready, w_timeout_err;

  assign w_retry_inc = (r_retry_cnt == '1) ? r_retry_cnt : r_retry_cnt + CNT_WIDTH'(1);
  assign w_loss_inc  = (r_loss_cnt  == '1) ? r_loss_cnt  : r_loss_cnt  + CNT_WIDTH'(1);

  // Registers, including the LOCKED synchronizer; r_sync2 is the usable lock.
  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (RST) begin
      r_state       <= S_RESET;
      r_cnt         <= '0;
      r_sync1       <= 1'b0;
      r_sync2       <= 1'b0;
      r_retry_cnt   <= '0;
      r_loss_cnt    <= '0;
      r_pll_rst     <= 1'b1;
      r_pll_pwrdwn  <= 1'b0;
      r_sys_rst     <= 1'b1;
      r_ready       <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_cnt         <= w_cnt;
      r_sync1       <= bus.LOCKED;
      r_sync2       <= r_sync1;
      r_retry_cnt   <= w_retry_cnt;
      r_loss_cnt    <= w_loss_cnt;
      r_pll_rst     <= w_pll_rst;
      r_pll_pwrdwn  <= w_pll_pwrdwn;
      r_sys_rst     <= w_sys_rst;
      r_ready       <= w_ready;
      r_timeout_err <= w_timeout_err;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no latches).
    w_next_state = r_state;
    w_retry_cnt  = r_retry_cnt;
    w_loss_cnt   = r_loss_cnt;
    w_cnt        = r_cnt;

    if (bus.PWRDWN_REQ && (r_state != S_FAIL)) begin
      w_next_state = S_PWRDN;
    end else begin
      case (r_state)
        S_RESET: begin
          if (r_cnt == RST_LAST) w_next_state = S_WAIT;
        end
        S_WAIT: begin
          // A lock seen on the timeout cycle wins over the retry.
          if (r_sync2) begin
            w_next_state = S_STABLE;
          end else if (r_cnt == TIMEOUT_LAST) begin
            w_retry_cnt  = w_retry_inc;
            w_next_state = ((MAX_R != 32'd0) && (32'(w_retry_inc) >= MAX_R)) ? S_FAIL : S_RESET;
          end
        end
        S_STABLE: begin
          if (!r_sync2)                  w_next_state = S_WAIT;
          else if (r_cnt == STABLE_LAST) w_next_state = S_RUN;
        end
        S_RUN: begin
          if (!r_sync2) begin
            w_loss_cnt   = w_loss_inc;
            w_next_state = S_RESET;
          end
        end
        S_FAIL:  w_next_state = S_FAIL;
        S_PWRDN: w_next_state = S_RESET;
        default: w_next_state = S_RESET;
      endcase
    end

    if (w_next_state != r_state) begin
      w_cnt = '0;
    end else if ((r_state == S_RESET) || (r_state == S_WAIT) || (r_state == S_STABLE)) begin
      w_cnt = r_cnt + CW'(1);
    end
  end

  // Outputs are decoded from the next state and registered above.
  always_comb begin
    w_pll_rst     = 1'b0;
    w_pll_pwrdwn  = 1'b0;
    w_sys_rst     = 1'b1;
    w_ready       = 1'b0;
    w_timeout_err = 1'b0;
    case (w_next_state)
      S_RESET:  w_pll_rst = 1'b1;
      S_RUN: begin
        w_sys_rst = 1'b0;
        w_ready   = 1'b1;
      end
      S_FAIL: begin
        w_pll_rst     = 1'b1;
        w_timeout_err = 1'b1;
      end
      S_PWRDN: begin
        w_pll_rst    = 1'b1;
        w_pll_pwrdwn = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.PLL_RST     = r_pll_rst;
  assign bus.PLL_PWRDWN  = r_pll_pwrdwn;
  assign bus.SYS_RST     = r_sys_rst;
  assign bus.READY       = r_ready;
  assign bus.TIMEOUT_ERR = r_timeout_err;
  assign bus.RETRY_CNT   = r_retry_cnt;
  assign bus.LOSS_CNT    = r_loss_cnt;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer: three parameter sets driven from one
// clock, outputs sampled 1 ns after each rising edge.
module tb_pll_lock_sequencer;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic rst_c = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  pll_lock_sequencer_if #(.CNT_WIDTH(8)) a_if ();
  pll_lock_sequencer_if #(.CNT_WIDTH(8)) b_if ();
  pll_lock_sequencer_if #(.CNT_WIDTH(2)) c_if ();

  pll_lock_sequencer u_a (.CLK(clk), .RST(rst_a), .bus(a_if));

  pll_lock_sequencer #(.LOCK_TIMEOUT(20), .MAX_RETRIES(3)) u_b (
    .CLK(clk), .RST(rst_b), .bus(b_if));

  pll_lock_sequencer #(.LOCK_TIMEOUT(20), .MAX_RETRIES(0), .CNT_WIDTH(2)) u_c (
    .CLK(clk), .RST(rst_c), .bus(c_if));

  // Flag order: {PLL_RST, PLL_PWRDWN, SYS_RST, READY, TIMEOUT_ERR}
  localparam logic [4:0] F_RESET  = 5'b10100;
  localparam logic [4:0] F_HOLD   = 5'b00100;
  localparam logic [4:0] F_RUN    = 5'b00010;
  localparam logic [4:0] F_PWRDN  = 5'b11100;
  localparam logic [4:0] F_FAIL   = 5'b10101;

  function automatic logic [4:0] flags_a();
    return {a_if.PLL_RST, a_if.PLL_PWRDWN, a_if.SYS_RST, a_if.READY, a_if.TIMEOUT_ERR};
  endfunction
  function automatic logic [4:0] flags_b();
    return {b_if.PLL_RST, b_if.PLL_PWRDWN, b_if.SYS_RST, b_if.READY, b_if.TIMEOUT_ERR};
  endfunction
  function automatic logic [4:0] flags_c();
    return {c_if.PLL_RST, c_if.PLL_PWRDWN, c_if.SYS_RST, c_if.READY, c_if.TIMEOUT_ERR};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else             n_pass++;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    a_if.LOCKED = 1'b1; a_if.PWRDWN_REQ = 1'b0;
    b_if.LOCKED = 1'b0; b_if.PWRDWN_REQ = 1'b0;
    c_if.LOCKED = 1'b0; c_if.PWRDWN_REQ = 1'b0;

    // Nominal relock with LOCKED tied high; RST released after edge 0.
    tick(2);
    check("a reset flags", flags_a(), F_RESET);
    check("a reset retry", a_if.RETRY_CNT, 0);
    check("a reset loss", a_if.LOSS_CNT, 0);
    rst_a = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      check($sformatf("a pll_rst edge %0d", k), a_if.PLL_RST, (k < 8) ? 1 : 0);
    end
    tick(16);
    check("a nominal edge24", flags_a(), F_HOLD);
    tick(1);
    check("a nominal edge25", flags_a(), F_RUN);
    check("a nominal retry", a_if.RETRY_CNT, 0);
    check("a nominal loss", a_if.LOSS_CNT, 0);

    // Lock loss in S_RUN for 3 cycles.
    a_if.LOCKED = 1'b0;
    tick(2);
    check("a loss +2 still ready", flags_a(), F_RUN);
    tick(1);
    check("a loss +3 flags", flags_a(), F_RESET);
    check("a loss cnt", a_if.LOSS_CNT, 1);
    a_if.LOCKED = 1'b1;
    tick(7);
    check("a loss pll_rst +10", a_if.PLL_RST, 1);
    tick(1);
    check("a loss pll_rst +11", a_if.PLL_RST, 0);
    tick(16);
    check("a relock +27", flags_a(), F_HOLD);
    tick(1);
    check("a relock +28", flags_a(), F_RUN);
    check("a relock loss", a_if.LOSS_CNT, 1);

    // Reset from S_RUN, then a one-cycle glitch during S_STABLE.
    rst_a = 1'b1;
    tick(1);
    check("a midrun reset flags", flags_a(), F_RESET);
    check("a midrun reset loss", a_if.LOSS_CNT, 0);
    rst_a = 1'b0;
    tick(19);
    check("a stable edge19", flags_a(), F_HOLD);
    a_if.LOCKED = 1'b0;
    tick(1);
    a_if.LOCKED = 1'b1;
    tick(18);
    check("a glitch edge38", flags_a(), F_HOLD);
    tick(1);
    check("a glitch edge39", flags_a(), F_RUN);
    check("a glitch loss", a_if.LOSS_CNT, 0);

    // Power-down request coinciding with a lock drop seen in S_RUN.
    a_if.LOCKED = 1'b0;
    tick(2);
    check("a pre-pwrdn ready", flags_a(), F_RUN);
    a_if.PWRDWN_REQ = 1'b1;
    tick(1);
    check("a pwrdn flags", flags_a(), F_PWRDN);
    check("a pwrdn loss", a_if.LOSS_CNT, 0);
    tick(3);
    check("a pwrdn held", flags_a(), F_PWRDN);
    a_if.PWRDWN_REQ = 1'b0;
    a_if.LOCKED     = 1'b1;
    tick(1);
    check("a pwrup flags", flags_a(), F_RESET);
    tick(7);
    check("a pwrup pll_rst +7", a_if.PLL_RST, 1);
    tick(1);
    check("a pwrup pll_rst +8", a_if.PLL_RST, 0);
    tick(16);
    check("a pwrup +24", flags_a(), F_HOLD);
    tick(1);
    check("a pwrup +25", flags_a(), F_RUN);
    check("a pwrup loss", a_if.LOSS_CNT, 0);
    check("a pwrup retry", a_if.RETRY_CNT, 0);

    // Timeouts into S_FAIL (LOCK_TIMEOUT=20, MAX_RETRIES=3).
    check("b reset flags", flags_b(), F_RESET);
    rst_b = 1'b0;
    tick(27);
    check("b retry edge27", b_if.RETRY_CNT, 0);
    tick(1);
    check("b retry edge28", b_if.RETRY_CNT, 1);
    check("b timeout1 flags", flags_b(), F_RESET);
    tick(7);
    check("b pll_rst edge35", b_if.PLL_RST, 1);
    tick(1);
    check("b pll_rst edge36", b_if.PLL_RST, 0);
    tick(20);
    check("b retry edge56", b_if.RETRY_CNT, 2);
    tick(27);
    check("b edge83 flags", flags_b(), F_HOLD);
    tick(1);
    check("b fail flags", flags_b(), F_FAIL);
    check("b fail retry", b_if.RETRY_CNT, 3);
    b_if.LOCKED     = 1'b1;
    b_if.PWRDWN_REQ = 1'b1;
    tick(10);
    check("b fail sticky", flags_b(), F_FAIL);
    check("b fail retry held", b_if.RETRY_CNT, 3);
    rst_b = 1'b1;
    tick(1);
    check("b rst from fail", flags_b(), F_RESET);
    check("b rst retry", b_if.RETRY_CNT, 0);

    // Lock arriving on the timeout cycle wins.
    b_if.PWRDWN_REQ = 1'b0;
    b_if.LOCKED     = 1'b0;
    rst_b           = 1'b0;
    tick(25);
    b_if.LOCKED = 1'b1;
    tick(3);
    check("b lock-wins flags", flags_b(), F_HOLD);
    check("b lock-wins retry", b_if.RETRY_CNT, 0);
    tick(15);
    check("b lock-wins edge43", flags_b(), F_HOLD);
    tick(1);
    check("b lock-wins edge44", flags_b(), F_RUN);

    // Saturation with unlimited retries (CNT_WIDTH=2, MAX_RETRIES=0).
    rst_c = 1'b0;
    for (int t = 1; t <= 5; t++) begin
      tick(28);
      check($sformatf("c retry %0d", t), c_if.RETRY_CNT, (t < 3) ? t : 3);
      check($sformatf("c flags %0d", t), flags_c(), F_RESET);
    end
    c_if.LOCKED = 1'b1;
    tick(12);
    check("c stable flags", flags_c(), F_HOLD);
    check("c stable retry", c_if.RETRY_CNT, 3);
    rst_c = 1'b1;
    tick(1);
    check("c midstable reset flags", flags_c(), F_RESET);
    check("c midstable reset retry", c_if.RETRY_CNT, 0);
    check("c midstable reset loss", c_if.LOSS_CNT, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
